fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer, fill level, full and almost-full flags.
// Defining FIFO_WR_OVF_EN adds the sticky overflow flag wr_ovf with its clear input wr_ovf_clr.
module fifo_wr_ctrl #(
  parameter int ADD_WIDTH    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_inc,
  input  logic [ADD_WIDTH:0]   rd_ptr,
`ifdef FIFO_WR_OVF_EN
  input  logic                 wr_ovf_clr,
  output logic                 wr_ovf,
`endif
  output logic [ADD_WIDTH:0]   wr_ptr,
  output logic [ADD_WIDTH-1:0] wr_addr,
  output logic                 wr_full,
  output logic                 wr_afull,
  output logic [ADD_WIDTH:0]   wr_level
);

  function automatic logic [ADD_WIDTH:0] bin2gray(input logic [ADD_WIDTH:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADD_WIDTH:0] gray2bin(input logic [ADD_WIDTH:0] g);
    logic [ADD_WIDTH:0] b;
    b[ADD_WIDTH] = g[ADD_WIDTH];
    for (int i = ADD_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADD_WIDTH:0] bin_q, bin_d;
  logic [ADD_WIDTH:0] ptr_q, ptr_d;
  logic [ADD_WIDTH:0] level_q, level_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               accept_s;
  logic [ADD_WIDTH:0] rd_bin_s;

  // Next-state: flags are derived from the post-write pointer so they are valid at the accepting edge.
  always_comb begin
    accept_s = wr_inc & ~full_q;
    if (accept_s) begin
      bin_d = bin_q + {{ADD_WIDTH{1'b0}}, 1'b1};
    end else begin
      bin_d = bin_q;
    end
    ptr_d    = bin2gray(bin_d);
    rd_bin_s = gray2bin(rd_ptr);
    level_d  = bin_d - rd_bin_s;
    // Gray full test: top two bits inverted, remainder equal.
    full_d   = (ptr_d == {~rd_ptr[ADD_WIDTH:ADD_WIDTH-1], rd_ptr[ADD_WIDTH-2:0]});
    afull_d  = (level_d >= (ADD_WIDTH+1)'(AFULL_THRESH));
  end

  // Pointer, level and flag registers.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      bin_q   <= '0;
      ptr_q   <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

  assign wr_ptr   = ptr_q;
  assign wr_addr  = bin_q[ADD_WIDTH-1:0];
  assign wr_full  = full_q;
  assign wr_afull = afull_q;
  assign wr_level = level_q;

`ifdef FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a rejected request sets it and wins over a same-cycle clear.
  always_comb begin
    if (wr_inc && full_q) begin
      ovf_d = 1'b1;
    end else if (wr_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign wr_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: count-based reference model, directed scenarios, randomized traffic.
module tb_fifo_wr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 12;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic          wr_inc = 1'b0;
  logic [AW:0]   rd_ptr = '0;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] wr_addr;
  logic          wr_full;
  logic          wr_afull;
  logic [AW:0]   wr_level;
  logic          ovf_clr = 1'b0;
`ifdef FIFO_WR_OVF_EN
  logic          wr_ovf;
`endif

  int total = 0;
  int bad   = 0;
  // Model: total accepted writes, read count seen at last edge, read count being driven, overflow.
  int mw = 0;
  int mr = 0;
  int rd_cnt = 0;
  bit mo = 1'b0;
  bit chk_en = 1'b0;

  fifo_wr_ctrl #(.ADD_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .wr_inc    (wr_inc),
    .rd_ptr    (rd_ptr),
`ifdef FIFO_WR_OVF_EN
    .wr_ovf_clr(ovf_clr),
    .wr_ovf    (wr_ovf),
`endif
    .wr_ptr    (wr_ptr),
    .wr_addr   (wr_addr),
    .wr_full   (wr_full),
    .wr_afull  (wr_afull),
    .wr_level  (wr_level)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [AW:0] gray(input int v);
    logic [31:0] t;
    logic [AW:0] b;
    t = v;
    b = t[AW:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, return at the next falling edge.
  task automatic step(input bit inc, input int rd_adv, input bit clr);
    bit was_full;
    wr_inc  = inc;
    rd_cnt  = rd_cnt + rd_adv;
    rd_ptr  = gray(rd_cnt);
    ovf_clr = clr;
    @(posedge wr_clk);
    #1;
    was_full = ((mw - mr) == DEPTH);
    if (inc && was_full) mo = 1'b1;
    else if (clr) mo = 1'b0;
    if (inc && !was_full) mw = mw + 1;
    mr = rd_cnt;
    @(negedge wr_clk);
  endtask

  task automatic model_reset();
    mw = 0; mr = 0; rd_cnt = 0; mo = 1'b0;
    rd_ptr = '0; wr_inc = 1'b0; ovf_clr = 1'b0;
  endtask

  // Per-cycle comparison of every output against the count-based model.
  always @(negedge wr_clk) begin
    if (chk_en) begin
      check("level",  int'(wr_level), mw - mr);
      check("full",   int'(wr_full),  ((mw - mr) == DEPTH) ? 1 : 0);
      check("afull",  int'(wr_afull), ((mw - mr) >= TH) ? 1 : 0);
      check("addr",   int'(wr_addr),  mw % DEPTH);
      check("wr_ptr", int'(wr_ptr),   int'(gray(mw)));
`ifdef FIFO_WR_OVF_EN
      check("ovf",    int'(wr_ovf),   int'(mo));
`endif
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_ptr"},   int'(wr_ptr),   0);
    check({nm, "_addr"},  int'(wr_addr),  0);
    check({nm, "_full"},  int'(wr_full),  0);
    check({nm, "_afull"}, int'(wr_afull), 0);
    check({nm, "_level"}, int'(wr_level), 0);
`ifdef FIFO_WR_OVF_EN
    check({nm, "_ovf"},   int'(wr_ovf),   0);
`endif
  endtask

  initial begin
    int p_wr;
    int p_rd;
    #1 wr_rst = 1'b0;
    #3;
    check_all_zero("rst");
    chk_en = 1'b1;
    @(negedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b1;

    // Fill from empty.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 0, 1'b0);
      if (i == 11) check("fill_afull11", int'(wr_afull), 0);
      if (i == 12) check("fill_afull12", int'(wr_afull), 1);
      if (i == 15) check("fill_full15",  int'(wr_full),  0);
    end
    check("fill_full16",  int'(wr_full),  1);
    check("fill_level16", int'(wr_level), 16);
    check("fill_ptr16",   int'(wr_ptr),   24);

    // Write while full.
    step(1'b1, 0, 1'b0);
    check("ovw_addr", int'(wr_addr), 0);
    check("ovw_ptr",  int'(wr_ptr),  24);
`ifdef FIFO_WR_OVF_EN
    check("ovw_ovf_set", int'(wr_ovf), 1);
    step(1'b0, 0, 1'b1);
    check("ovw_ovf_clr", int'(wr_ovf), 0);
`endif

    // Read advance together with write requests at level 16.
    step(1'b1, 1, 1'b0);
    step(1'b1, 0, 1'b0);
    check("rw_level", int'(wr_level), 16);
    check("rw_full",  int'(wr_full),  1);
    check("rw_ptr",   int'(wr_ptr),   25);
    step(1'b0, 0, 1'b1);

    // Drain to level 3, then write and read together across the pointer wrap.
    while (mw - rd_cnt > 3) step(1'b0, 1, 1'b0);
    check("drain_level", int'(wr_level), 3);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1, 1'b0);
      check("wrap_level", int'(wr_level), 3);
      check("wrap_full",  int'(wr_full),  0);
    end

    // Reset pulsed between edges at level 9.
    for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b0);
    check("pre_rst_level", int'(wr_level), 9);
    #2 wr_rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    @(negedge wr_clk);
    wr_rst = 1'b1;
    check("post_rst_addr", int'(wr_addr), 0);
    step(1'b1, 0, 1'b0);
    check("post_rst_level", int'(wr_level), 1);

    // Randomized traffic with varying write/read bias to visit empty, full and overflow.
    for (int blk = 0; blk < 8; blk++) begin
      p_wr = (blk % 2 == 0) ? 80 : 30;
      p_rd = (blk % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(0, 99) < p_wr) ? 1'b1 : 1'b0,
             ((rd_cnt < mw) && ($urandom_range(0, 99) < p_rd)) ? 1 : 0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
